hilo_unit: RTL and testbench

Sequencer and result store that sits directly downstream of the iterative divider. It accepts a divide request from decode, drives the divider's start/operand inputs and waits on its busy flag. It then commits quotient to LO and remainder to HI, and holds both for mfhi/mflo reads and mthi/mtlo writes. It stalls the pipeline for the whole operation and flags divide-by-zero and divider timeouts.

---
 rtl/hilo_pkg.sv | 8 +
 rtl/hilo_if.sv | 35 +++
 rtl/hilo_regs.sv | 49 ++++
 rtl/hilo_unit.sv | 91 +++++++++
 tb/tb_hilo_unit.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hilo_pkg.sv
// Shared types and constants for the HI/LO divide sequencer.
package hilo_pkg;
  localparam int WORD_W      = 32;
  localparam int TIMEOUT_DEF = 64;
  localparam int CNT_W_DEF   = 7;

  typedef enum logic [1:0] {IDLE, START, WAIT, COMMIT} state_t;
endpackage

// File: rtl/hilo_if.sv
// Decode-side and divider-side signals of hilo_unit, bundled as one interface.
interface hilo_if;
  import hilo_pkg::*;

  // Handshakes: div_req is a one-cycle request accepted only while the unit is idle;
  // stall rises one cycle after acceptance, so decode must never issue back-to-back requests.
  // div_start is a one-cycle pulse; the divider result is taken on the first WAIT cycle with div_busy low.
  logic              div_req;
  logic [WORD_W-1:0] div_a;
  logic [WORD_W-1:0] div_b;
  logic              wr_hi;
  logic              wr_lo;
  logic [WORD_W-1:0] wr_data;
  logic              div_start;
  logic [WORD_W-1:0] div_dividend;
  logic [WORD_W-1:0] div_divisor;
  logic              div_busy;
  logic [WORD_W-1:0] div_q;
  logic [WORD_W-1:0] div_r;
  logic [WORD_W-1:0] hi;
  logic [WORD_W-1:0] lo;
  logic              stall;
  logic              dz;
  logic              tmo;

  modport slave (
    input  div_req, div_a, div_b, wr_hi, wr_lo, wr_data, div_busy, div_q, div_r,
    output div_start, div_dividend, div_divisor, hi, lo, stall, dz, tmo
  );

  modport master (
    output div_req, div_a, div_b, wr_hi, wr_lo, wr_data, div_busy, div_q, div_r,
    input  div_start, div_dividend, div_divisor, hi, lo, stall, dz, tmo
  );
endinterface

// File: rtl/hilo_regs.sv
// HI/LO register pair with write mux. Define HILO_FWD_EN to bypass the next value
// combinationally onto hi/lo; otherwise hi/lo are the raw registers.
module hilo_regs
  import hilo_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              wr_hi,
  input  logic              wr_lo,
  input  logic              commit,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [WORD_W-1:0] div_q,
  input  logic [WORD_W-1:0] div_r,
  output logic [WORD_W-1:0] hi,
  output logic [WORD_W-1:0] lo
);
  logic [WORD_W-1:0] hi_q, lo_q, hi_d, lo_d;

  // Commit and writes are mutually exclusive by state; commit wins if both were ever asserted.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit) begin
      hi_d = div_r;
      lo_d = div_q;
    end else begin
      if (wr_hi) hi_d = wr_data;
      if (wr_lo) lo_d = wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

`ifdef HILO_FWD_EN
  assign hi = hi_d;
  assign lo = lo_d;
`else
  assign hi = hi_q;
  assign lo = lo_q;
`endif
endmodule

// File: rtl/hilo_unit.sv
// Divide sequencer: launches the divider, waits on busy with a timeout, commits q/r to LO/HI.
// Optional HILO_FWD_EN (see hilo_regs) forwards HI/LO writes combinationally.
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic   clock,
  input  logic   reset_n,
  hilo_if.slave  bus,
  output state_t dbg_state
);
  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              in_idle, accept, reject, timed_out;
  logic              div_start_q, stall_q, dz_q, tmo_q;
  logic [WORD_W-1:0] dividend_q, divisor_q;

  assign in_idle   = (state == IDLE);
  assign accept    = in_idle && bus.div_req && (bus.div_b != '0);
  assign reject    = in_idle && bus.div_req && (bus.div_b == '0);
  assign timed_out = (state == WAIT) && bus.div_busy && (cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = START;
      START:   state_nx = WAIT;
      WAIT:    if (!bus.div_busy) state_nx = COMMIT;
               else if (timed_out) state_nx = IDLE;
      COMMIT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                       cnt <= '0;
    else if (state == START)            cnt <= '0;
    else if (state == WAIT && bus.div_busy) cnt <= cnt + 1'b1;
  end

  // stall is registered and excludes the START cycle, so it covers N+1 up to the commit edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_start_q <= 1'b0;
      stall_q     <= 1'b0;
      dz_q        <= 1'b0;
      tmo_q       <= 1'b0;
      dividend_q  <= '0;
      divisor_q   <= '0;
    end else begin
      div_start_q <= (state_nx == START);
      stall_q     <= (state != IDLE) && (state_nx != IDLE);
      if (accept) begin
        dividend_q <= bus.div_a;
        divisor_q  <= bus.div_b;
      end
      if (accept)      dz_q <= 1'b0;
      else if (reject) dz_q <= 1'b1;
      if (accept || reject) tmo_q <= 1'b0;
      else if (timed_out)   tmo_q <= 1'b1;
    end
  end

  hilo_regs u_regs (
    .clock   (clock),
    .reset_n (reset_n),
    .wr_hi   (in_idle && bus.wr_hi),
    .wr_lo   (in_idle && bus.wr_lo),
    .commit  (state == COMMIT),
    .wr_data (bus.wr_data),
    .div_q   (bus.div_q),
    .div_r   (bus.div_r),
    .hi      (bus.hi),
    .lo      (bus.lo)
  );

  assign bus.div_start    = div_start_q;
  assign bus.div_dividend = dividend_q;
  assign bus.div_divisor  = divisor_q;
  assign bus.stall        = stall_q;
  assign bus.dz           = dz_q;
  assign bus.tmo          = tmo_q;
  assign dbg_state        = state;
endmodule

// File: tb/tb_hilo_unit.sv
// Randomized scoreboard bench for hilo_unit with a behavioural divider and reference model.
module tb_hilo_unit;
  import hilo_pkg::*;

  localparam int TMO = 8;

  typedef struct {
    logic [31:0] hi, lo, dividend, divisor;
    logic        dz, tmo;
    int          stall_cycles, start_cycles;
  } exp_t;

  logic   clock, reset_n;
  state_t dbg_state;
  hilo_if bus();

  hilo_unit #(.TIMEOUT(TMO), .CNT_W(4)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  int   checks = 0, failures = 0;
  exp_t exp_q[$];
  logic [31:0] hi_m = 0, lo_m = 0, opa_m = 0, opb_m = 0;
  logic        dz_m = 0, tmo_m = 0;
  int   lat_cfg = 0;
  bit   mon_mute = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] divmod(input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    sa = $signed(a);
    sb = $signed(b);
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // ---------------- behavioural divider ----------------
  int bcnt;
  assign bus.div_busy = (bcnt != 0);
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bcnt      <= 0;
      bus.div_q <= '0;
      bus.div_r <= '0;
    end else if (bus.div_start) begin
      bcnt <= lat_cfg;
      {bus.div_r, bus.div_q} <= divmod(bus.div_dividend, bus.div_divisor);
    end else if (bcnt != 0) begin
      bcnt <= bcnt - 1;
    end
  end

  // ---------------- monitor ----------------
  int   stall_cnt = 0, start_cnt = 0;
  logic prev_stall = 0, prev_dz = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (bus.stall)     stall_cnt++;
      if (bus.div_start) start_cnt++;
      if (mon_mute || !reset_n) begin
        stall_cnt = 0;
        start_cnt = 0;
      end else if ((prev_stall && !bus.stall) || (!prev_dz && bus.dz && !bus.stall)) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_completion: stall=%0b dz=%0b with empty queue", bus.stall, bus.dz);
        end else begin
          e = exp_q.pop_front();
          check("hi", bus.hi, e.hi);
          check("lo", bus.lo, e.lo);
          check("dz", {31'b0, bus.dz}, {31'b0, e.dz});
          check("tmo", {31'b0, bus.tmo}, {31'b0, e.tmo});
          check("stall_cycles", stall_cnt, e.stall_cycles);
          check("start_pulses", start_cnt, e.start_cycles);
          check("div_dividend", bus.div_dividend, e.dividend);
          check("div_divisor", bus.div_divisor, e.divisor);
        end
        stall_cnt = 0;
        start_cnt = 0;
      end
      prev_stall = bus.stall;
      prev_dz    = bus.dz;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_done();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clock);
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL op_completion: %0d expected results not seen within 40 cycles", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_write(input logic h, input logic l, input logic [31:0] d);
    logic [31:0] old_hi, old_lo;
    old_hi = hi_m;
    old_lo = lo_m;
    @(negedge clock); #1;
    bus.wr_hi = h; bus.wr_lo = l; bus.wr_data = d;
    if (h) hi_m = d;
    if (l) lo_m = d;
    #1;
`ifdef HILO_FWD_EN
    check("wr_hi_same_cycle", bus.hi, hi_m);
    check("wr_lo_same_cycle", bus.lo, lo_m);
`else
    check("wr_hi_same_cycle", bus.hi, old_hi);
    check("wr_lo_same_cycle", bus.lo, old_lo);
`endif
    @(posedge clock); #1;
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
    check("wr_hi_next_cycle", bus.hi, hi_m);
    check("wr_lo_next_cycle", bus.lo, lo_m);
  endtask

  // co_wr: mthi in the same cycle as the request; mid_wr: mtlo while the divide runs.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int lat,
                       input bit co_wr, input bit mid_wr);
    exp_t e;
    logic [63:0] qr;
    @(negedge clock); #1;
    lat_cfg = lat;
    bus.div_req = 1'b1; bus.div_a = a; bus.div_b = b;
    if (co_wr) begin
      bus.wr_hi = 1'b1; bus.wr_data = $urandom;
      hi_m = bus.wr_data;
    end
    e.start_cycles = 1;
    if (b == 0) begin
      dz_m = 1; tmo_m = 0;
      e.stall_cycles = 0;
      e.start_cycles = 0;
    end else begin
      opa_m = a; opb_m = b; dz_m = 0;
      if (lat >= TMO) begin
        tmo_m = 1;
        e.stall_cycles = TMO;
      end else begin
        qr = divmod(a, b);
        lo_m = qr[31:0]; hi_m = qr[63:32]; tmo_m = 0;
        e.stall_cycles = 2 + lat;
      end
    end
    e.hi = hi_m; e.lo = lo_m; e.dz = dz_m; e.tmo = tmo_m;
    e.dividend = opa_m; e.divisor = opb_m;
    exp_q.push_back(e);
    @(negedge clock); #1;
    bus.div_req = 1'b0; bus.wr_hi = 1'b0;
    if (mid_wr) begin
      @(negedge clock); #1;
      bus.wr_lo = 1'b1; bus.wr_data = $urandom;
      @(negedge clock); #1;
      bus.wr_lo = 1'b0;
    end
    wait_done();
  endtask

  task automatic reset_mid_op();
    mon_mute = 1;
    @(negedge clock); #1;
    lat_cfg = 20;
    bus.div_req = 1'b1; bus.div_a = 32'd999; bus.div_b = 32'd3;
    @(negedge clock); #1;
    bus.div_req = 1'b0;
    repeat (3) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    check("rst_state", {30'b0, dbg_state}, {30'b0, IDLE});
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    check("rst_stall", {31'b0, bus.stall}, 0);
    @(negedge clock); #1 reset_n = 1'b1;
    hi_m = 0; lo_m = 0; opa_m = 0; opb_m = 0; dz_m = 0; tmo_m = 0;
    repeat (12) @(negedge clock);
    check("post_rst_hi", bus.hi, 0);
    check("post_rst_lo", bus.lo, 0);
    check("post_rst_stall", {31'b0, bus.stall}, 0);
    check("post_rst_dividend", bus.div_dividend, 0);
    mon_mute = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] a, b;
    reset_n = 1'b0;
    bus.div_req = 0; bus.div_a = 0; bus.div_b = 0;
    bus.wr_hi = 0; bus.wr_lo = 0; bus.wr_data = 0;
    #12;
    check("reset_hi", bus.hi, 0);
    check("reset_lo", bus.lo, 0);
    check("reset_stall", {31'b0, bus.stall}, 0);
    check("reset_dz_tmo", {30'b0, bus.dz, bus.tmo}, 0);
    check("reset_start", {31'b0, bus.div_start}, 0);
    check("reset_operands", bus.div_dividend | bus.div_divisor, 0);
    @(negedge clock); #1 reset_n = 1'b1;

    do_op(32'd100, 32'd7, 0, 0, 0);
    do_op(32'hFFFF_FF9C, 32'd7, 0, 0, 0);
    do_write(1, 0, 32'h11);
    do_write(0, 1, 32'h22);
    do_op(32'd5, 32'd0, 0, 0, 0);
    do_op(32'd123, 32'd10, 20, 0, 0);
    do_op(32'd50, 32'd6, 3, 0, 0);
    do_op(32'd77, 32'd5, TMO - 1, 0, 0);
    do_op(32'd77, 32'd5, TMO, 0, 0);
    do_write(1, 0, 32'hDEADBEEF);
    do_op(32'd9, 32'd4, 20, 0, 1);
    do_op(32'd9, 32'hFFFF_FFFC, 2, 1, 0);
    do_write(1, 1, $urandom);
    reset_mid_op();
    do_op(32'hFFFF_FC18, 32'd33, 1, 0, 0);

    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2, 3: b = ($urandom_range(0, 1) != 0) ? -$urandom_range(1, 20) : $urandom_range(1, 20);
        default: b = $urandom;
      endcase
      if (b == 0 && dz_m) b = 32'd1;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd1;
      if ($urandom_range(0, 3) == 0)
        do_write($urandom_range(0, 1), $urandom_range(0, 1), $urandom);
      do_op(a, b, $urandom_range(0, TMO + 2), $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
    end

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
